// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected MAC array: FSM encoding and
// default parameter values used by the top and the lane sub-module.
package fc_pkg;

    localparam int DEF_IN_DATA_WIDTH = 8;
    localparam int DEF_NUM_LANES     = 4;
    localparam int DEF_ACC_WIDTH     = 32;
    localparam int DEF_OUT_WIDTH     = 16;
    localparam int DEF_LEN_WIDTH     = 10;
    localparam bit DEF_RELU_EN       = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } fc_state_t;

endpackage

// File: rtl/fc_mac_lane.sv
// One output neuron: signed multiply-accumulate with bias preload, followed by
// optional ReLU and saturation into a registered result.
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
    parameter bit RELU_EN       = DEF_RELU_EN
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load,
    input  logic                        acc_en,
    input  logic                        capture,
    input  logic signed [IN_DATA_WIDTH-1:0] bias,
    input  logic signed [IN_DATA_WIDTH-1:0] node,
    input  logic signed [IN_DATA_WIDTH-1:0] wegt,
    output logic signed [OUT_WIDTH-1:0]     result
);

    localparam int PW = 2 * IN_DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] relu_val;
    logic signed [PW-1:0]        prod;
    logic signed [OUT_WIDTH-1:0] sat_val;

    // Post-processing works on acc_next so the result is ready on the same
    // edge that absorbs the final beat (or the bias, for zero-length jobs).
    always_comb begin
        prod = PW'(node) * PW'(wegt);
        if (load)
            acc_next = {{(ACC_WIDTH-IN_DATA_WIDTH){bias[IN_DATA_WIDTH-1]}}, bias};
        else if (acc_en)
            acc_next = acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        else
            acc_next = acc;

        if (RELU_EN && acc_next[ACC_WIDTH-1])
            relu_val = '0;
        else
            relu_val = acc_next;

        if (relu_val > SAT_MAX)
            sat_val = SAT_MAX[OUT_WIDTH-1:0];
        else if (relu_val < SAT_MIN)
            sat_val = SAT_MIN[OUT_WIDTH-1:0];
        else
            sat_val = relu_val[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            result <= '0;
        end else begin
            acc <= acc_next;
            if (capture)
                result <= sat_val;
        end
    end

endmodule

// File: rtl/fc_mac_array.sv
// Fully-connected layer slice: NUM_LANES neurons share a streamed input vector,
// each with its own weight stream and bias; results leave via valid/ready.
module fc_mac_array
    import fc_pkg::*;
#(
    parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int NUM_LANES     = DEF_NUM_LANES,
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH     = DEF_OUT_WIDTH,
    parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
    parameter bit RELU_EN       = DEF_RELU_EN
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_run,
    input  logic [LEN_WIDTH-1:0]               i_len,
    input  logic [NUM_LANES*IN_DATA_WIDTH-1:0] i_bias,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [IN_DATA_WIDTH-1:0]           i_node,
    input  logic [NUM_LANES*IN_DATA_WIDTH-1:0] i_wegt,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [NUM_LANES*OUT_WIDTH-1:0]     o_result,
    output logic                               o_busy,
    output logic                               o_done
);

    // A full-length job of worst-case products must not wrap the accumulator.
    if (ACC_WIDTH < 2*IN_DATA_WIDTH + LEN_WIDTH) begin : g_bad_acc_width
        $error("fc_mac_array: ACC_WIDTH too small for IN_DATA_WIDTH and LEN_WIDTH");
    end

    fc_state_t            state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic                 start;
    logic                 beat;
    logic                 last_beat;
    logic                 capture;

    assign start     = (state == ST_IDLE) && i_run;
    assign beat      = (state == ST_ACCUM) && i_valid;
    assign last_beat = beat && (LEN_WIDTH'(beat_cnt + 1'b1) == len_q);
    assign capture   = (start && (i_len == '0)) || last_beat;

    assign o_ready = (state == ST_ACCUM);
    assign o_valid = (state == ST_OUT);
    assign o_busy  = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            beat_cnt <= '0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_run) begin
                        len_q    <= i_len;
                        beat_cnt <= '0;
                        state    <= (i_len != '0) ? ST_ACCUM : ST_OUT;
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat)
                            state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (i_ready) begin
                        state  <= ST_IDLE;
                        o_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        fc_mac_lane #(
            .IN_DATA_WIDTH(IN_DATA_WIDTH),
            .ACC_WIDTH    (ACC_WIDTH),
            .OUT_WIDTH    (OUT_WIDTH),
            .RELU_EN      (RELU_EN)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .load   (start),
            .acc_en (beat),
            .capture(capture),
            .bias   (i_bias[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .node   (i_node),
            .wegt   (i_wegt[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]),
            .result (o_result[k*OUT_WIDTH +: OUT_WIDTH])
        );
    end

endmodule

// File: doc/fc_mac_array.md
FC_MAC_ARRAY -- requirements
Module: fc_mac_array

Interface
REQ-001 SHALL have parameters: IN_DATA_WIDTH, default 8, signed node/weight/bias width.
REQ-002 SHALL have parameters: NUM_LANES, default 4, number of parallel output neurons.
REQ-003 SHALL have parameters: ACC_WIDTH, default 32, signed accumulator width.
REQ-004 SHALL have parameters: OUT_WIDTH, default 16, signed result width per lane.
REQ-005 SHALL have parameters: LEN_WIDTH, default 10, input-length counter width.
REQ-006 SHALL have parameters: RELU_EN, default 1, 1 = apply ReLU to results.
REQ-007 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-008 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-009 SHALL have ports: i_run  in  1  start pulse, sampled only in IDLE.
REQ-010 SHALL have ports: i_len  in  LEN_WIDTH  number of input beats, sampled with i_run.
REQ-011 SHALL have ports: i_bias  in  NUM_LANES*IN_DATA_WIDTH  per-lane signed bias, sampled with i_run; lane k at bits [k*IN_DATA_WIDTH +: IN_DATA_WIDTH].
REQ-012 SHALL have ports: i_valid  in  1  input beat valid.
REQ-013 SHALL have ports: o_ready  out  1  block accepts input beat.
REQ-014 SHALL have ports: i_node  in  IN_DATA_WIDTH  signed input activation, shared by all lanes.
REQ-015 SHALL have ports: i_wegt  in  NUM_LANES*IN_DATA_WIDTH  per-lane signed weights, same packing as i_bias.
REQ-016 SHALL have ports: o_valid  out  1  result valid.
REQ-017 SHALL have ports: i_ready  in  1  downstream accepts result.
REQ-018 SHALL have ports: o_result  out  NUM_LANES*OUT_WIDTH  per-lane signed results, lane k at bits [k*OUT_WIDTH +: OUT_WIDTH].
REQ-019 SHALL have ports: o_busy  out  1  high in any state other than IDLE.
REQ-020 SHALL have ports: o_done  out  1  one-cycle pulse on result handshake.

Function
REQ-021 SHALL implement states IDLE, ACCUM, OUT.
REQ-022 IDLE: o_ready=0, o_valid=0; i_run=1 SHALL latch i_len, load each accumulator with sign-extended bias, clear beat counter; next state ACCUM if i_len!=0, else OUT.
REQ-023 ACCUM: o_ready SHALL be 1; beat accepted iff i_valid&&o_ready; each accepted beat SHALL add signed i_node*i_wegt[k] (sign-extended to ACC_WIDTH) to lane k and increment counter.
REQ-024 Accepting beat number i_len SHALL move to OUT on the next edge; o_valid SHALL assert the cycle after the last beat (1-cycle latency); i_valid gaps SHALL stall without effect.
REQ-025 OUT: o_ready=0, o_valid=1; o_result SHALL be registered and held stable until i_valid... i_ready=1; on handshake: next state IDLE, o_done=1 for exactly one cycle.
REQ-026 Post-processing per lane SHALL be: ReLU (negative to 0) when RELU_EN=1, then saturate to signed OUT_WIDTH range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-027 Accumulator SHALL wrap modulo 2^ACC_WIDTH; ACC_WIDTH >= 2*IN_DATA_WIDTH+LEN_WIDTH is a legal-parameter requirement, flagged by elaboration check.
REQ-028 i_run outside IDLE SHALL be ignored; i_valid outside ACCUM SHALL be ignored.
REQ-029 i_run and i_ready handshake in the same cycle SHALL not start a new job; i_run is honoured only in the following IDLE cycle.

Reset
REQ-030 reset=1 SHALL asynchronously force IDLE, counter=0, accumulators=0, o_result=0, o_valid=0, o_ready=0, o_busy=0, o_done=0.
REQ-031 reset asserted mid-ACCUM or mid-OUT SHALL abandon the job with no o_done and no o_valid after release.

Structure
REQ-032 Package fc_pkg SHALL hold state encoding constants and default parameter values.
REQ-033 One sub-module fc_mac_lane SHALL hold one lane's multiply, accumulator, ReLU and saturation, instantiated NUM_LANES times via generate.

Verification
REQ-034 Basic dot product: defaults, i_len=3, bias={0:1,1:2,2:3,3:-4}, nodes 2,3,-1, all weights 1 -> o_result lanes {5,6,7,0}, o_valid 1 cycle after beat 3.
REQ-035 Saturation: i_len=4, bias 0, node=-128, weight=-128 every lane -> accumulator 65536, o_result 32767 each lane.
REQ-036 ReLU/zero length: i_len=0, bias -5 all lanes -> OUT next cycle, o_result 0; with RELU_EN=0 -> -5.
REQ-037 Backpressure and gaps: i_valid toggling 1/0, i_ready low 5 cycles in OUT -> o_result stable, single o_done on handshake.
REQ-038 Reset mid-ACCUM after 2 of 4 beats -> all outputs 0, IDLE; new job i_len=1 computes correct result.
REQ-039 i_run pulsed during ACCUM and OUT -> ignored, job result unchanged.
